// File: rtl/tm1638_sched_types.sv
// Shared types and constants for the TM1638 frame scheduler.
//   sched_state_t : scheduler FSM states (also exported on the diagnostic port)
//   word_t        : one SPI FIFO word, {last, byte}; last=1 releases STB after the byte
//   CMD_*         : TM1638 command bytes used by the scheduler
//   disp_ctrl()   : builds the display-control command byte
//   seg_addr()    : display RAM address of segment grid n
//   led_addr()    : display RAM address of LED n
package tm1638_sched_types;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CFG  = 3'd1,
        CMD  = 3'd2,
        ADDR = 3'd3,
        DATA = 3'd4
    } sched_state_t;

    // Data command: write, fixed address.
    localparam logic [7:0] CMD_DATA_FIXED = 8'h44;
    // Address command base; low nibble carries the RAM address.
    localparam logic [7:0] CMD_ADDR       = 8'hC0;
    // Display control base; bit3 = on, bits[2:0] = brightness.
    localparam logic [7:0] CMD_DISP       = 8'h80;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } word_t;

    function automatic logic [7:0] disp_ctrl(input logic on, input logic [2:0] bright);
        return CMD_DISP | {4'b0000, on, bright};
    endfunction

    function automatic logic [3:0] seg_addr(input logic [2:0] grid);
        return {grid, 1'b0};
    endfunction

    function automatic logic [3:0] led_addr(input logic [2:0] led);
        return {led, 1'b1};
    endfunction

endpackage

// File: rtl/tm1638_rr_pick.sv
// Combinational 16-way round-robin picker.
//   req     : one request bit per display RAM address
//   ptr     : search starts here, wrapping 15 -> 0
//   gnt_idx : first requesting index at or after ptr (0 when nothing requests)
//   any     : at least one request bit is set
module tm1638_rr_pick (
    input  logic [15:0] req,
    input  logic [3:0]  ptr,
    output logic [3:0]  gnt_idx,
    output logic        any
);

    always_comb begin
        gnt_idx = 4'd0;
        any     = |req;
        // Walk from the farthest offset down so the nearest request is the last one written.
        for (int i = 15; i >= 0; i--) begin
            if (req[ptr + 4'(i)]) begin
                gnt_idx = ptr + 4'(i);
            end
        end
    end

endmodule

// File: rtl/tm1638_sched.sv
// TM1638 frame scheduler.
// Keeps a shadow of the 16-byte display RAM plus display-control state, marks changed
// addresses dirty, and turns pending changes into TM1638 command frames for the SPI FIFO.
// Display-control frames go first; address frames are served round-robin, one at a time.
//   i_Clk, i_Rst          : clock, synchronous active-high reset
//   i_Seg_Valid/Grid/Data : write a segment byte to RAM address 2*grid
//   i_Leds_Valid, i_Leds  : LED n drives bit0 of RAM address 2n+1
//   i_Cfg_Valid, i_Bright, i_Display_On : display-control update
//   o_Word, o_Word_Valid  : registered FIFO word {last, byte} and its valid
//   i_FIFO_Full           : FIFO backpressure; a word moves when valid && !full
//   o_Busy                : a frame is in flight or something is still pending
//   o_Diag_State          : current scheduler state
module tm1638_sched
    import tm1638_sched_types::*;
#(
    parameter logic [2:0] DEFAULT_BRIGHT = 3'd7,
    parameter logic       DEFAULT_ON     = 1'b1
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_Seg_Valid,
    input  logic [2:0]   i_Seg_Grid,
    input  logic [7:0]   i_Seg_Data,
    input  logic         i_Leds_Valid,
    input  logic [7:0]   i_Leds,
    input  logic         i_Cfg_Valid,
    input  logic [2:0]   i_Bright,
    input  logic         i_Display_On,
    output logic [8:0]   o_Word,
    output logic         o_Word_Valid,
    input  logic         i_FIFO_Full,
    output logic         o_Busy,
    output sched_state_t o_Diag_State
);

    // Shadow of display RAM and control state.
    logic [7:0]   ram_q [16];
    logic [7:0]   ram_d [16];
    logic [15:0]  dirty_q, dirty_d;
    logic         cfg_dirty_q, cfg_dirty_d;
    logic [2:0]   bright_q, bright_d;
    logic         on_q, on_d;

    // Scheduler state.
    sched_state_t state_q, state_d;
    logic [3:0]   rr_ptr_q, rr_ptr_d;
    logic [3:0]   addr_q, addr_d;
    // Payload byte latched at frame start: the control byte for CFG, ram[a] for address frames.
    logic [7:0]   data_q, data_d;

    // Registered FIFO interface.
    word_t        word_q, word_d;
    logic         valid_q, valid_d;

    logic         accept;
    logic [3:0]   pick_idx;
    logic         pick_any;

    tm1638_rr_pick u_rr_pick (
        .req     (dirty_q),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign accept = valid_q && !i_FIFO_Full;

    always_comb begin
        ram_d       = ram_q;
        dirty_d     = dirty_q;
        cfg_dirty_d = cfg_dirty_q;
        bright_d    = bright_q;
        on_d        = on_q;
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        word_d      = word_q;
        valid_d     = valid_q;

        unique case (state_q)
            IDLE: begin
                if (cfg_dirty_q) begin
                    data_d      = disp_ctrl(on_q, bright_q);
                    cfg_dirty_d = 1'b0;
                    word_d.last = 1'b1;
                    word_d.data = disp_ctrl(on_q, bright_q);
                    valid_d     = 1'b1;
                    state_d     = CFG;
                end else if (pick_any) begin
                    addr_d            = pick_idx;
                    data_d            = ram_q[pick_idx];
                    dirty_d[pick_idx] = 1'b0;
                    rr_ptr_d          = pick_idx + 4'd1;
                    word_d.last       = 1'b1;
                    word_d.data       = CMD_DATA_FIXED;
                    valid_d           = 1'b1;
                    state_d           = CMD;
                end
            end
            CFG: begin
                if (accept) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            CMD: begin
                if (accept) begin
                    // STB stays low between the address and data bytes.
                    word_d.last = 1'b0;
                    word_d.data = CMD_ADDR | {4'b0000, addr_q};
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                if (accept) begin
                    word_d.last = 1'b1;
                    word_d.data = data_q;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Producer writes come after the pick so a set in the same cycle beats the clear.
        if (i_Seg_Valid) begin
            ram_d[seg_addr(i_Seg_Grid)]   = i_Seg_Data;
            dirty_d[seg_addr(i_Seg_Grid)] = 1'b1;
        end

        if (i_Leds_Valid) begin
            for (int n = 0; n < 8; n++) begin
                if (i_Leds[n] != ram_q[led_addr(3'(n))][0]) begin
                    ram_d[led_addr(3'(n))]   = {7'b0000000, i_Leds[n]};
                    dirty_d[led_addr(3'(n))] = 1'b1;
                end
            end
        end

        if (i_Cfg_Valid) begin
            bright_d    = i_Bright;
            on_d        = i_Display_On;
            cfg_dirty_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            // Everything dirty: the first pass after reset rewrites the whole display.
            ram_q       <= '{default: 8'h00};
            dirty_q     <= 16'hFFFF;
            cfg_dirty_q <= 1'b1;
            bright_q    <= DEFAULT_BRIGHT;
            on_q        <= DEFAULT_ON;
            state_q     <= IDLE;
            rr_ptr_q    <= 4'd0;
            addr_q      <= 4'd0;
            data_q      <= 8'h00;
            word_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            ram_q       <= ram_d;
            dirty_q     <= dirty_d;
            cfg_dirty_q <= cfg_dirty_d;
            bright_q    <= bright_d;
            on_q        <= on_d;
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
        end
    end

    assign o_Word       = word_q;
    assign o_Word_Valid = valid_q;
    assign o_Busy       = (state_q != IDLE) || (|dirty_q) || cfg_dirty_q;
    assign o_Diag_State = state_q;

endmodule

// File: tb/tb_tm1638_sched.sv
// Self-checking bench for tm1638_sched: directed frame-sequence checks followed by
// randomized writes with random FIFO backpressure, checked against a display image
// rebuilt from the frames that actually reached the FIFO.
module tb_tm1638_sched;
    import tm1638_sched_types::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         seg_valid = 1'b0;
    logic [2:0]   seg_grid = '0;
    logic [7:0]   seg_data = '0;
    logic         leds_valid = 1'b0;
    logic [7:0]   leds = '0;
    logic         cfg_valid = 1'b0;
    logic [2:0]   bright = '0;
    logic         disp_on = 1'b0;
    logic         full = 1'b0;
    logic [8:0]   word;
    logic         word_valid;
    logic         busy;
    sched_state_t st;

    always #5 clk = ~clk;

    tm1638_sched #(
        .DEFAULT_BRIGHT (3'd7),
        .DEFAULT_ON     (1'b1)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Seg_Valid  (seg_valid),
        .i_Seg_Grid   (seg_grid),
        .i_Seg_Data   (seg_data),
        .i_Leds_Valid (leds_valid),
        .i_Leds       (leds),
        .i_Cfg_Valid  (cfg_valid),
        .i_Bright     (bright),
        .i_Display_On (disp_on),
        .o_Word       (word),
        .o_Word_Valid (word_valid),
        .i_FIFO_Full  (full),
        .o_Busy       (busy),
        .o_Diag_State (st)
    );

    int checks = 0;
    int failures = 0;

    // Words pushed into the FIFO, and the expected list for the current directed step.
    logic [8:0] wq[$];
    logic [8:0] exp_q[$];

    // Display as the TM1638 would see it, decoded from pushed frames.
    logic [7:0] disp[16];
    logic [7:0] disp_ctrl_seen = 8'h00;
    int         ph = 0;
    logic [3:0] pa = '0;
    int         proto_err = 0;

    // Reference shadow from producer writes.
    logic [7:0] exp_ram[16];
    logic [2:0] exp_bright = 3'd7;
    logic       exp_on = 1'b1;

    // Inputs change 1 time unit after posedge, so negedge sees the cycle's final values.
    always @(negedge clk) begin
        if (rst) begin
            ph = 0;
        end else if (word_valid && !full) begin
            wq.push_back(word);
            case (ph)
                0: begin
                    if (word == 9'h144) begin
                        ph = 1;
                    end else if (word[8] && (word[7:4] == 4'h8 || word[7:4] == 4'h9)) begin
                        disp_ctrl_seen = word[7:0];
                    end else begin
                        proto_err++;
                    end
                end
                1: begin
                    if (word[8:4] == 5'b01100) begin
                        pa = word[3:0];
                        ph = 2;
                    end else begin
                        proto_err++;
                        ph = 0;
                    end
                end
                default: begin
                    if (word[8]) disp[pa] = word[7:0];
                    else proto_err++;
                    ph = 0;
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sv, input logic [2:0] g, input logic [7:0] d,
                         input logic lv, input logic [7:0] l,
                         input logic cv, input logic [2:0] b, input logic o);
        seg_valid  = sv;
        seg_grid   = g;
        seg_data   = d;
        leds_valid = lv;
        leds       = l;
        cfg_valid  = cv;
        bright     = b;
        disp_on    = o;
        if (sv) exp_ram[{g, 1'b0}] = d;
        if (lv) for (int n = 0; n < 8; n++) exp_ram[{3'(n), 1'b1}] = {7'b0, l[n]};
        if (cv) begin
            exp_bright = b;
            exp_on     = o;
        end
        step();
        seg_valid  = 1'b0;
        leds_valid = 1'b0;
        cfg_valid  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget, input bit rnd, output int n);
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            if (rnd) full = ($urandom_range(0, 3) == 0);
            step();
            n++;
        end
        full = 1'b0;
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_words(input string tag);
        chk({tag, "_count"}, 32'(wq.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wq.size()) chk($sformatf("%s_w%0d", tag, i), 32'(wq[i]), 32'(exp_q[i]));
        end
        wq.delete();
    endtask

    task automatic chk_image(input string tag);
        for (int a = 0; a < 16; a++) begin
            chk($sformatf("%s_ram%0h", tag, a), 32'(disp[a]), 32'(exp_ram[a]));
        end
        chk({tag, "_ctrl"}, 32'(disp_ctrl_seen), 32'(8'h80 | {exp_on, exp_bright}));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int a = 0; a < 16; a++) begin
            exp_ram[a] = 8'h00;
            disp[a]    = 8'h55;
        end

        // Reset state.
        rst = 1'b1;
        repeat (3) step();
        chk("rst_valid", 32'(word_valid), 32'd0);
        chk("rst_word", 32'(word), 32'd0);
        chk("rst_state", 32'(st), 32'(IDLE));
        chk("rst_busy", 32'(busy), 32'd1);

        // Init sequence: control frame, then all 16 addresses cleared.
        rst = 1'b0;
        wait_idle("init", 300, 1'b0, n);
        chk("init_cycles", 32'(n), 32'd66);
        exp_q = {9'h18F};
        for (int a = 0; a < 16; a++) begin
            exp_q.push_back(9'h144);
            exp_q.push_back({1'b0, 8'hC0 | 8'(a)});
            exp_q.push_back(9'h100);
        end
        chk_words("init");
        chk_image("init");

        // Single segment write.
        drive(1'b1, 3'd3, 8'h5B, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        wait_idle("seg", 100, 1'b0, n);
        exp_q = {9'h144, 9'h0C6, 9'h15B};
        chk_words("seg");

        // LEDs: only changed bits produce frames; rr_ptr is 7 so 0xF comes before 0x1.
        drive(1'b0, 3'd0, 8'h00, 1'b1, 8'h81, 1'b0, 3'd0, 1'b0);
        wait_idle("leds", 100, 1'b0, n);
        exp_q = {9'h144, 9'h0CF, 9'h101, 9'h144, 9'h0C1, 9'h101};
        chk_words("leds");
        drive(1'b0, 3'd0, 8'h00, 1'b1, 8'h81, 1'b0, 3'd0, 1'b0);
        wait_idle("leds_rep", 100, 1'b0, n);
        exp_q.delete();
        chk_words("leds_rep");

        // Config arriving mid-frame waits for the frame to finish.
        drive(1'b1, 3'd0, 8'h11, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 20 && st != DATA; i++) step();
        chk("cfg_reach_data", 32'(st), 32'(DATA));
        drive(1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b1, 3'd2, 1'b0);
        wait_idle("cfg", 100, 1'b0, n);
        exp_q = {9'h144, 9'h0C0, 9'h111, 9'h182};
        chk_words("cfg");

        // Backpressure during ADDR holds the word stable.
        drive(1'b1, 3'd5, 8'hA5, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 20 && st != ADDR; i++) step();
        chk("stall_reach_addr", 32'(st), 32'(ADDR));
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("stall_word%0d", i), 32'(word), 32'h0CA);
            chk($sformatf("stall_valid%0d", i), 32'(word_valid), 32'd1);
        end
        full = 1'b0;
        wait_idle("stall", 100, 1'b0, n);
        exp_q = {9'h144, 9'h0CA, 9'h1A5};
        chk_words("stall");

        // Write landing in the same cycle IDLE picks the address: old value then new value.
        drive(1'b1, 3'd2, 8'h3C, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        drive(1'b1, 3'd2, 8'hC3, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        wait_idle("setwin", 100, 1'b0, n);
        exp_q = {9'h144, 9'h0C4, 9'h13C, 9'h144, 9'h0C4, 9'h1C3};
        chk_words("setwin");

        // Wrap: rr_ptr left at 0xF, dirty {0xE, 0x1} -> 1 first, then 0xE.
        drive(1'b1, 3'd7, 8'h77, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
        wait_idle("wrap_a", 100, 1'b0, n);
        exp_q = {9'h144, 9'h0CE, 9'h177};
        chk_words("wrap_a");
        drive(1'b1, 3'd7, 8'hE1, 1'b1, 8'h80, 1'b0, 3'd0, 1'b0);
        wait_idle("wrap_b", 100, 1'b0, n);
        exp_q = {9'h144, 9'h0C1, 9'h100, 9'h144, 9'h0CE, 9'h1E1};
        chk_words("wrap_b");
        chk_image("directed");

        // Random bursts with random backpressure; the decoded display must converge.
        for (int k = 0; k < 25; k++) begin
            int len;
            len = $urandom_range(1, 15);
            for (int c = 0; c < len; c++) begin
                full = ($urandom_range(0, 3) == 0);
                drive(1'($urandom_range(0, 2) == 0), 3'($urandom), 8'($urandom),
                      1'($urandom_range(0, 3) == 0), 8'($urandom),
                      1'($urandom_range(0, 5) == 0), 3'($urandom), 1'($urandom));
            end
            wait_idle($sformatf("rand%0d", k), 3000, 1'b1, n);
            wq.delete();
            chk_image($sformatf("rand%0d", k));
        end

        chk("protocol", 32'(proto_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
